sirv_gnrl_axi64_to_icb32: RTL and testbench

SIRV_GNRL_AXI64_TO_ICB32 -- requirements
Module: sirv_gnrl_axi64_to_icb32

---
 rtl/sirv_gnrl_axi64_to_icb32.sv | 194 +++++++++++++++++++
 tb/tb_sirv_gnrl_axi64_to_icb32.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sirv_gnrl_axi64_to_icb32.sv
// Bridges single-beat 64-bit AXI reads/writes onto a 32-bit ICB master port,
// splitting each transaction into at most two 32-bit ICB commands (low half first).
module sirv_gnrl_axi64_to_icb32 #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          i_axi_arvalid,
  output logic          i_axi_arready,
  input  logic [AW-1:0] i_axi_araddr,
  input  logic [2:0]    i_axi_arsize,
  input  logic [7:0]    i_axi_arlen,
  input  logic [1:0]    i_axi_arburst,

  input  logic          i_axi_awvalid,
  output logic          i_axi_awready,
  input  logic [AW-1:0] i_axi_awaddr,
  input  logic [2:0]    i_axi_awsize,
  input  logic [7:0]    i_axi_awlen,
  input  logic [1:0]    i_axi_awburst,

  input  logic          i_axi_wvalid,
  output logic          i_axi_wready,
  input  logic [63:0]   i_axi_wdata,
  input  logic [7:0]    i_axi_wstrb,
  input  logic          i_axi_wlast,

  output logic          i_axi_rvalid,
  input  logic          i_axi_rready,
  output logic [63:0]   i_axi_rdata,
  output logic [1:0]    i_axi_rresp,
  output logic          i_axi_rlast,

  output logic          i_axi_bvalid,
  input  logic          i_axi_bready,
  output logic [1:0]    i_axi_bresp,

  output logic          o_icb_cmd_valid,
  input  logic          o_icb_cmd_ready,
  output logic          o_icb_cmd_read,
  output logic [AW-1:0] o_icb_cmd_addr,
  output logic [31:0]   o_icb_cmd_wdata,
  output logic [3:0]    o_icb_cmd_wmask,
  output logic [1:0]    o_icb_cmd_size,

  input  logic          o_icb_rsp_valid,
  output logic          o_icb_rsp_ready,
  input  logic          o_icb_rsp_err,
  input  logic [31:0]   o_icb_rsp_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RSP,
    RRESP,
    BRESP
  } state_t;

  state_t        state;
  logic          last_grant_wr;
  logic          is_read;
  logic [AW-1:0] addr_q;
  logic [2:0]    size_q;
  logic [63:0]   wdata_q;
  logic [7:0]    wstrb_q;
  logic          need_lo;
  logic          need_hi;
  logic [63:0]   rbuf;
  logic          err_q;

  logic rd_cand;
  logic wr_cand;
  logic grant_rd;
  logic grant_wr;
  logic half;
  logic narrow_rd;

  // Burst attributes are meaningless for a single-beat bridge.
  logic unused_attr;
  assign unused_attr = ^{i_axi_arlen, i_axi_arburst, i_axi_awsize,
                         i_axi_awlen, i_axi_awburst, i_axi_wlast};

  assign rd_cand  = i_axi_arvalid;
  assign wr_cand  = i_axi_awvalid & i_axi_wvalid;
  assign grant_rd = (state == IDLE) & rd_cand & (~wr_cand | last_grant_wr);
  assign grant_wr = (state == IDLE) & wr_cand & (~rd_cand | ~last_grant_wr);

  assign i_axi_arready = grant_rd;
  assign i_axi_awready = grant_wr;
  assign i_axi_wready  = grant_wr;

  // The low half is always serviced first, so the active half is simply "low done".
  assign half      = ~need_lo;
  assign narrow_rd = is_read & (size_q != 3'd3);

  assign o_icb_cmd_valid = (state == CMD);
  assign o_icb_cmd_read  = is_read;
  assign o_icb_cmd_addr  = narrow_rd ? addr_q : {addr_q[AW-1:3], half, 2'b00};
  assign o_icb_cmd_size  = narrow_rd ? size_q[1:0] : 2'b10;
  assign o_icb_cmd_wdata = is_read ? 32'h0 : (half ? wdata_q[63:32] : wdata_q[31:0]);
  assign o_icb_cmd_wmask = is_read ? 4'h0  : (half ? wstrb_q[7:4]   : wstrb_q[3:0]);
  assign o_icb_rsp_ready = (state == RSP);

  assign i_axi_rvalid = (state == RRESP);
  assign i_axi_rdata  = rbuf;
  assign i_axi_rresp  = err_q ? 2'b10 : 2'b00;
  assign i_axi_rlast  = 1'b1;
  assign i_axi_bvalid = (state == BRESP);
  assign i_axi_bresp  = err_q ? 2'b10 : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant_wr <= 1'b1;
      is_read       <= 1'b0;
      // NOTE: the datapath registers are reset too, so an abandoned transaction
      // leaves no stale address, data or read-buffer contents behind.
      addr_q        <= '0;
      size_q        <= 3'd0;
      wdata_q       <= 64'h0;
      wstrb_q       <= 8'h0;
      need_lo       <= 1'b0;
      need_hi       <= 1'b0;
      rbuf          <= 64'h0;
      err_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below reads
      // the pre-edge values of need_lo/need_hi/err_q regardless of statement order.
      case (state)
        IDLE: begin
          if (grant_rd) begin
            is_read       <= 1'b1;
            addr_q        <= i_axi_araddr;
            size_q        <= i_axi_arsize;
            need_lo       <= (i_axi_arsize == 3'd3) | ~i_axi_araddr[2];
            need_hi       <= (i_axi_arsize == 3'd3) |  i_axi_araddr[2];
            rbuf          <= 64'h0;
            err_q         <= 1'b0;
            last_grant_wr <= 1'b0;
            state         <= CMD;
          end else if (grant_wr) begin
            is_read       <= 1'b0;
            addr_q        <= i_axi_awaddr;
            wdata_q       <= i_axi_wdata;
            wstrb_q       <= i_axi_wstrb;
            need_lo       <= |i_axi_wstrb[3:0];
            need_hi       <= |i_axi_wstrb[7:4];
            err_q         <= 1'b0;
            last_grant_wr <= 1'b1;
            // An all-zero strobe has nothing to write; answer immediately.
            state         <= (|i_axi_wstrb) ? CMD : BRESP;
          end
        end

        CMD: begin
          if (o_icb_cmd_ready) state <= RSP;
        end

        RSP: begin
          if (o_icb_rsp_valid) begin
            if (is_read) begin
              if (half) rbuf[63:32] <= o_icb_rsp_rdata;
              else      rbuf[31:0]  <= o_icb_rsp_rdata;
            end
            err_q <= err_q | o_icb_rsp_err;
            if (half) need_hi <= 1'b0;
            else      need_lo <= 1'b0;
            if (~half & need_hi) state <= CMD;
            else                 state <= is_read ? RRESP : BRESP;
          end
        end

        RRESP: begin
          if (i_axi_rready) begin
            state <= IDLE;
            err_q <= 1'b0;
          end
        end

        BRESP: begin
          if (i_axi_bready) begin
            state <= IDLE;
            err_q <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sirv_gnrl_axi64_to_icb32.sv
// Scoreboard bench: AXI stimulus pushes expected ICB commands and R/B responses;
// an ICB slave model and an AXI response monitor pop and compare them.
module tb_sirv_gnrl_axi64_to_icb32;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;

  logic          i_axi_arvalid, i_axi_arready;
  logic [AW-1:0] i_axi_araddr;
  logic [2:0]    i_axi_arsize;
  logic [7:0]    i_axi_arlen;
  logic [1:0]    i_axi_arburst;
  logic          i_axi_awvalid, i_axi_awready;
  logic [AW-1:0] i_axi_awaddr;
  logic [2:0]    i_axi_awsize;
  logic [7:0]    i_axi_awlen;
  logic [1:0]    i_axi_awburst;
  logic          i_axi_wvalid, i_axi_wready;
  logic [63:0]   i_axi_wdata;
  logic [7:0]    i_axi_wstrb;
  logic          i_axi_wlast;
  logic          i_axi_rvalid, i_axi_rready;
  logic [63:0]   i_axi_rdata;
  logic [1:0]    i_axi_rresp;
  logic          i_axi_rlast;
  logic          i_axi_bvalid, i_axi_bready;
  logic [1:0]    i_axi_bresp;
  logic          o_icb_cmd_valid, o_icb_cmd_ready, o_icb_cmd_read;
  logic [AW-1:0] o_icb_cmd_addr;
  logic [31:0]   o_icb_cmd_wdata;
  logic [3:0]    o_icb_cmd_wmask;
  logic [1:0]    o_icb_cmd_size;
  logic          o_icb_rsp_valid, o_icb_rsp_ready, o_icb_rsp_err;
  logic [31:0]   o_icb_rsp_rdata;

  always #5 clk = ~clk;

  sirv_gnrl_axi64_to_icb32 #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_axi_arvalid(i_axi_arvalid), .i_axi_arready(i_axi_arready), .i_axi_araddr(i_axi_araddr),
    .i_axi_arsize(i_axi_arsize), .i_axi_arlen(i_axi_arlen), .i_axi_arburst(i_axi_arburst),
    .i_axi_awvalid(i_axi_awvalid), .i_axi_awready(i_axi_awready), .i_axi_awaddr(i_axi_awaddr),
    .i_axi_awsize(i_axi_awsize), .i_axi_awlen(i_axi_awlen), .i_axi_awburst(i_axi_awburst),
    .i_axi_wvalid(i_axi_wvalid), .i_axi_wready(i_axi_wready), .i_axi_wdata(i_axi_wdata),
    .i_axi_wstrb(i_axi_wstrb), .i_axi_wlast(i_axi_wlast),
    .i_axi_rvalid(i_axi_rvalid), .i_axi_rready(i_axi_rready), .i_axi_rdata(i_axi_rdata),
    .i_axi_rresp(i_axi_rresp), .i_axi_rlast(i_axi_rlast),
    .i_axi_bvalid(i_axi_bvalid), .i_axi_bready(i_axi_bready), .i_axi_bresp(i_axi_bresp),
    .o_icb_cmd_valid(o_icb_cmd_valid), .o_icb_cmd_ready(o_icb_cmd_ready), .o_icb_cmd_read(o_icb_cmd_read),
    .o_icb_cmd_addr(o_icb_cmd_addr), .o_icb_cmd_wdata(o_icb_cmd_wdata), .o_icb_cmd_wmask(o_icb_cmd_wmask),
    .o_icb_cmd_size(o_icb_cmd_size),
    .o_icb_rsp_valid(o_icb_rsp_valid), .o_icb_rsp_ready(o_icb_rsp_ready), .o_icb_rsp_err(o_icb_rsp_err),
    .o_icb_rsp_rdata(o_icb_rsp_rdata)
  );

  typedef struct {
    logic        read;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [1:0]  size;
    logic [31:0] rdata;
    logic        err;
  } icb_exp_t;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
  } axi_exp_t;

  icb_exp_t icb_q[$];
  axi_exp_t r_q[$];
  axi_exp_t b_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  bit stall    = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
  endtask

  // Expected-value model for one AXI read.
  task automatic push_read(input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input bit e0, input bit e1);
    icb_exp_t c;
    axi_exp_t r;
    bit lo, hi, err;
    lo = (size == 3'd3) || !addr[2];
    hi = (size == 3'd3) ||  addr[2];
    err = 1'b0;
    r.data = 64'h0;
    c.read = 1'b1; c.wdata = 32'h0; c.wmask = 4'h0;
    c.size = (size == 3'd3) ? 2'b10 : size[1:0];
    if (lo) begin
      c.addr = (size == 3'd3) ? {addr[31:3], 3'b000} : addr;
      c.rdata = d0; c.err = e0;
      icb_q.push_back(c);
      r.data[31:0] = d0; err |= e0;
    end
    if (hi) begin
      c.addr = (size == 3'd3) ? {addr[31:3], 3'b100} : addr;
      c.rdata = d1; c.err = e1;
      icb_q.push_back(c);
      r.data[63:32] = d1; err |= e1;
    end
    r.resp = err ? 2'b10 : 2'b00;
    r_q.push_back(r);
  endtask

  task automatic push_write(input logic [31:0] addr, input logic [63:0] wd,
                            input logic [7:0] ws, input bit e0, input bit e1);
    icb_exp_t c;
    axi_exp_t b;
    bit err;
    err = 1'b0;
    c.read = 1'b0; c.size = 2'b10; c.rdata = 32'h0;
    if (|ws[3:0]) begin
      c.addr = {addr[31:3], 3'b000}; c.wdata = wd[31:0]; c.wmask = ws[3:0]; c.err = e0;
      icb_q.push_back(c); err |= e0;
    end
    if (|ws[7:4]) begin
      c.addr = {addr[31:3], 3'b100}; c.wdata = wd[63:32]; c.wmask = ws[7:4]; c.err = e1;
      icb_q.push_back(c); err |= e1;
    end
    b.data = 64'h0;
    b.resp = err ? 2'b10 : 2'b00;
    b_q.push_back(b);
  endtask

  // ICB slave: checks each accepted command, answers one cycle later.
  icb_exp_t cur;
  bit cmd_pend, rsp_fire;
  initial begin
    o_icb_cmd_ready = 1'b1; o_icb_rsp_valid = 1'b0; o_icb_rsp_err = 1'b0; o_icb_rsp_rdata = 32'h0;
    cmd_pend = 1'b0; rsp_fire = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        o_icb_rsp_valid = 1'b0; cmd_pend = 1'b0; rsp_fire = 1'b0; o_icb_cmd_ready = 1'b1;
        continue;
      end
      if (rsp_fire) o_icb_rsp_valid = 1'b0;
      if (cmd_pend && !o_icb_rsp_valid) begin
        o_icb_rsp_valid = 1'b1; o_icb_rsp_rdata = cur.rdata; o_icb_rsp_err = cur.err; cmd_pend = 1'b0;
      end
      o_icb_cmd_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      rsp_fire = o_icb_rsp_valid && o_icb_rsp_ready;
      if (o_icb_cmd_valid && o_icb_cmd_ready) begin
        if (icb_q.size() == 0) check("icb_unexpected_cmd", 1'b1, 1'b0);
        else begin
          cur = icb_q.pop_front();
          check("cmd_read",  o_icb_cmd_read,  cur.read);
          check("cmd_addr",  o_icb_cmd_addr,  cur.addr);
          check("cmd_size",  o_icb_cmd_size,  cur.size);
          check("cmd_wdata", o_icb_cmd_wdata, cur.wdata);
          check("cmd_wmask", o_icb_cmd_wmask, cur.wmask);
          cmd_pend = 1'b1;
        end
      end
    end
  end

  // AXI R/B monitor.
  initial begin
    axi_exp_t e;
    i_axi_rready = 1'b1; i_axi_bready = 1'b1;
    forever begin
      @(negedge clk);
      i_axi_rready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      i_axi_bready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      #1;
      if (rst_n && i_axi_rvalid && i_axi_rready) begin
        if (r_q.size() == 0) check("r_unexpected", 1'b1, 1'b0);
        else begin
          e = r_q.pop_front();
          check("rdata", i_axi_rdata, e.data);
          check("rresp", i_axi_rresp, e.resp);
          check("rlast", i_axi_rlast, 1'b1);
        end
      end
      if (rst_n && i_axi_bvalid && i_axi_bready) begin
        if (b_q.size() == 0) check("b_unexpected", 1'b1, 1'b0);
        else begin
          e = b_q.pop_front();
          check("bresp", i_axi_bresp, e.resp);
        end
      end
    end
  end

  task automatic drive_ar(input logic [31:0] addr, input logic [2:0] size);
    int k;
    @(negedge clk);
    i_axi_arvalid = 1'b1; i_axi_araddr = addr; i_axi_arsize = size;
    i_axi_arlen = 8'($urandom); i_axi_arburst = 2'($urandom);
    k = 0;
    #1;
    while (!i_axi_arready && k < 100) begin @(negedge clk); #1; k++; end
    if (k == 100) check("ar_accept_timeout", 1'b0, 1'b1);
    @(negedge clk);
    i_axi_arvalid = 1'b0;
  endtask

  task automatic drive_aw(input logic [31:0] addr, input logic [63:0] wd, input logic [7:0] ws);
    int k;
    @(negedge clk);
    i_axi_awvalid = 1'b1; i_axi_wvalid = 1'b1; i_axi_awaddr = addr; i_axi_wdata = wd; i_axi_wstrb = ws;
    i_axi_awlen = 8'($urandom); i_axi_wlast = 1'($urandom);
    k = 0;
    #1;
    while (!(i_axi_awready && i_axi_wready) && k < 100) begin @(negedge clk); #1; k++; end
    if (k == 100) check("aw_accept_timeout", 1'b0, 1'b1);
    @(negedge clk);
    i_axi_awvalid = 1'b0; i_axi_wvalid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while ((icb_q.size() != 0 || r_q.size() != 0 || b_q.size() != 0) && k < 500) begin
      @(negedge clk); #2; k++;
    end
    if (k == 500) check("drain_timeout", 1'b0, 1'b1);
    @(negedge clk);
  endtask

  // Cycles from the accept edge until rvalid is seen.
  task automatic measure_r_latency(input string tag, input int exp);
    int n;
    n = 1;
    #1;
    while (!i_axi_rvalid && n < 50) begin @(negedge clk); #1; n++; end
    check(tag, n, exp);
  endtask

  initial begin
    int k;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [7:0]  ws;
    rst_n = 1'b0;
    i_axi_arvalid = 1'b0; i_axi_araddr = '0; i_axi_arsize = 3'd0; i_axi_arlen = 8'h0; i_axi_arburst = 2'b01;
    i_axi_awvalid = 1'b0; i_axi_awaddr = '0; i_axi_awsize = 3'd3; i_axi_awlen = 8'h0; i_axi_awburst = 2'b01;
    i_axi_wvalid = 1'b0; i_axi_wdata = 64'h0; i_axi_wstrb = 8'h0; i_axi_wlast = 1'b1;

    // Reset state.
    @(negedge clk); #1;
    check("rst_arready",   i_axi_arready,   1'b0);
    check("rst_awready",   i_axi_awready,   1'b0);
    check("rst_cmd_valid", o_icb_cmd_valid, 1'b0);
    check("rst_rsp_ready", o_icb_rsp_ready, 1'b0);
    check("rst_rvalid",    i_axi_rvalid,    1'b0);
    check("rst_bvalid",    i_axi_bvalid,    1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // 64-bit read split into two commands.
    push_read(32'h100, 3'd3, 32'h11111111, 32'h22222222, 1'b0, 1'b0);
    drive_ar(32'h100, 3'd3);
    measure_r_latency("lat_read64", 5);
    wait_done();

    // 32-bit read of the upper half.
    push_read(32'h104, 3'd2, 32'h0, 32'h55667788, 1'b0, 1'b0);
    drive_ar(32'h104, 3'd2);
    measure_r_latency("lat_read32", 3);
    wait_done();

    // Upper-half-only write.
    push_write(32'h200, 64'hAABBCCDD_11223344, 8'hF0, 1'b0, 1'b0);
    drive_aw(32'h200, 64'hAABBCCDD_11223344, 8'hF0);
    wait_done();

    // Empty-strobe write answers the cycle after acceptance.
    push_write(32'h208, 64'hDEADBEEF_CAFEF00D, 8'h00, 1'b0, 1'b0);
    drive_aw(32'h208, 64'hDEADBEEF_CAFEF00D, 8'h00);
    #1;
    check("b_zero_strobe_lat", i_axi_bvalid, 1'b1);
    wait_done();

    // Reset while waiting on an ICB response abandons the write.
    push_write(32'h400, 64'h01234567_89ABCDEF, 8'hFF, 1'b0, 1'b0);
    drive_aw(32'h400, 64'h01234567_89ABCDEF, 8'hFF);
    k = 0;
    #1;
    while (!o_icb_rsp_ready && k < 50) begin @(negedge clk); #1; k++; end
    check("reached_rsp", o_icb_rsp_ready, 1'b1);
    #1;
    rst_n = 1'b0;
    icb_q.delete(); r_q.delete(); b_q.delete();
    #1;
    check("midrst_cmd_valid", o_icb_cmd_valid, 1'b0);
    check("midrst_rsp_ready", o_icb_rsp_ready, 1'b0);
    check("midrst_bvalid",    i_axi_bvalid,    1'b0);
    check("midrst_rvalid",    i_axi_rvalid,    1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk); #1;
      check("postrst_bvalid",    i_axi_bvalid,    1'b0);
      check("postrst_cmd_valid", o_icb_cmd_valid, 1'b0);
    end

    // Contention right after reset: read wins first, write wins the next contest.
    push_read(32'h300, 3'd3, 32'h0000000A, 32'h0000000B, 1'b0, 1'b1);
    push_write(32'h310, 64'h0, 8'h0F, 1'b0, 1'b0);
    push_read(32'h320, 3'd2, 32'h33334444, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    i_axi_arvalid = 1'b1; i_axi_araddr = 32'h300; i_axi_arsize = 3'd3;
    i_axi_awvalid = 1'b1; i_axi_wvalid = 1'b1; i_axi_awaddr = 32'h310;
    i_axi_wdata = 64'h0; i_axi_wstrb = 8'h0F;
    #1;
    check("contest1_arready", i_axi_arready, 1'b1);
    check("contest1_awready", i_axi_awready, 1'b0);
    check("contest1_wready",  i_axi_wready,  1'b0);
    @(negedge clk);
    i_axi_arvalid = 1'b0;
    k = 0;
    #1;
    while (!i_axi_rvalid && k < 100) begin @(negedge clk); #1; k++; end
    i_axi_arvalid = 1'b1; i_axi_araddr = 32'h320; i_axi_arsize = 3'd2;
    @(negedge clk); #1;
    check("contest2_awready", i_axi_awready, 1'b1);
    check("contest2_arready", i_axi_arready, 1'b0);
    @(negedge clk);
    i_axi_awvalid = 1'b0; i_axi_wvalid = 1'b0;
    k = 0;
    #1;
    while (!i_axi_arready && k < 100) begin @(negedge clk); #1; k++; end
    check("read2_accepted", i_axi_arready, 1'b1);
    @(negedge clk);
    i_axi_arvalid = 1'b0;
    wait_done();

    // Randomised traffic with ICB and AXI back-pressure.
    stall = 1'b1;
    for (int i = 0; i < 24; i++) begin
      a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 1) == 1) begin
        sz = 3'($urandom_range(0, 3));
        push_read(a, sz, $urandom, $urandom, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
        drive_ar(a, sz);
      end else begin
        ws = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
        i_axi_wdata = {$urandom, $urandom};
        push_write(a, i_axi_wdata, ws, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
        drive_aw(a, i_axi_wdata, ws);
      end
      wait_done();
    end
    stall = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
